axis_broadcaster_buffered: RTL
==============================

// Module: axis_broadcaster_buffered
// PURPOSE
//  Replicates one AXI-stream input to NUM_STREAMS outputs. Each output has its own FIFO, so a
//  stalled consumer does not block the others until its FIFO fills. A per-packet destination
//  mask selects which outputs receive each packet. Sits between a packet source and fan-out
//  consumers (e.g. parallel protocol checkers or capture paths).
// PARAMETERS
//  AXIS_BYTES      1   tdata width in bytes
//  AXIS_USER_BITS  1   tuser width
//  NUM_STREAMS     2   number of outputs, >=1
//  FIFO_DEPTH      4   per-output FIFO depth in beats, power of two, >=2
//  DROP_CNT_BITS   16  width of the dropped-packet counter
// PORTS
//  clk             in   1                          clock; all logic is in this domain
//  sreset          in   1                          synchronous reset, active-high
//  axis_i_tready   out  1                          input ready
//  axis_i_tvalid   in   1                          input valid
//  axis_i_tlast    in   1                          input last beat of packet
//  axis_i_tdata    in   AXIS_BYTES*8               input data
//  axis_i_tuser    in   AXIS_USER_BITS             input user
//  axis_i_mask     in   NUM_STREAMS                destination mask; sampled on a packet's first beat only
//  axis_o_tready   in   NUM_STREAMS                per-output ready
//  axis_o_tvalid   out  NUM_STREAMS                per-output valid
//  axis_o_tlast    out  NUM_STREAMS                per-output last
//  axis_o_tdata    out  NUM_STREAMS*AXIS_BYTES*8   output data; stream i occupies slice i
//  axis_o_tuser    out  NUM_STREAMS*AXIS_USER_BITS output user; stream i occupies slice i
//  drop_count      out  DROP_CNT_BITS              saturating count of packets sent with mask==0
// BEHAVIOUR
//  - Reset (sreset=1 at a clk edge):
//      all FIFOs empty; axis_o_tvalid=0; drop_count=0; state=IDLE; mask register=0.
//      axis_i_tready is 0 during reset.
//  - State machine (packet tracking):
//      IDLE: first beat of a packet; active mask = axis_i_mask.
//      IN_PKT: active mask = mask register.
//      IDLE->IN_PKT on an accepted beat with tlast=0; the mask register loads axis_i_mask.
//      IN_PKT->IDLE on an accepted beat with tlast=1.
//      A single-beat packet stays in IDLE.
//  - axis_i_tready = !sreset && for every i with active_mask[i]=1, FIFO i is not full.
//      Depends only on FIFO occupancy and the mask.
//      No combinational path from axis_o_tready to axis_i_tready.
//  - Accept = axis_i_tvalid && axis_i_tready.
//      On accept, {tdata,tuser,tlast} is pushed into every FIFO with active_mask[i]=1.
//      Unselected FIFOs are untouched.
//  - Mask==0: beats are accepted (tready=1) and discarded.
//      drop_count increments by 1 on the accepted first beat of such a packet and saturates
//      at all-ones.
//  - Latency: a beat accepted at edge N is presented on axis_o_* after edge N.
//      Valid is registered; one cycle minimum.
//  - Outputs: AXI-stream compliant. Once asserted, tvalid and data stay stable until
//      axis_o_tready[i].
//  - FIFO full: a FIFO that is full at the edge does not accept a push, even if it pops that
//      same edge. Simultaneous push and pop on a non-full, non-empty FIFO keeps the count
//      unchanged. Simultaneous push and pop on an empty FIFO is not possible, because there is
//      no fall-through.
//  - Pointers: log2(FIFO_DEPTH)+1 bits, wrapping naturally.
//      full  = MSBs differ and the rest are equal.
//      empty = pointers are equal.
//  - Reset mid-packet: all FIFO contents are discarded, including partial packets, and the
//      state machine returns to IDLE. The next accepted beat is treated as a packet start.
//  - axis_i_mask changes while in IN_PKT are ignored.
//  - Throughput: 1 beat/cycle per output when every selected consumer holds tready=1.
// STRUCTURE
//  - Package axis_broadcaster_pkg:
//      function to compute the pointer width from FIFO_DEPTH;
//      typedef enum {IDLE, IN_PKT} for the state.
//  - Sub-module axis_sync_fifo: single-clock FIFO, parameters WIDTH and DEPTH, with sreset.
//    Instantiated NUM_STREAMS times in a generate loop. Payload = {tlast,tuser,tdata}.
//  - Top level holds the state machine, the mask register, ready/accept logic and drop_count.
// TESTING
//  1. Reset and broadcast.
//     Stimulus: NUM_STREAMS=2, all tready=1, mask=2'b11; send 3-beat packet 0xA1,0xA2,0xA3.
//     Required: both outputs show the same 3 beats, tlast on 0xA3, 1-cycle latency, tready
//     never drops.
//  2. Mask sampled at first beat only.
//     Stimulus: first beat mask=2'b01, then mask switched to 2'b10 mid-packet on a 4-beat
//     packet.
//     Required: all 4 beats appear on output 0 only; output 1 never asserts tvalid.
//  3. Slow consumer isolation.
//     Stimulus: FIFO_DEPTH=4, tready[1]=0, mask=2'b01, 10 beats.
//     Required: all 10 beats reach output 0; FIFO 1 is not used.
//     Then mask=2'b11 with tready[1]=0.
//     Required: input tready falls after 4 beats are accepted.
//  4. Full boundary.
//     Stimulus: FIFO 0 full (count 4); in one cycle assert tready[0]=1 and input tvalid=1.
//     Required: the pop occurs, the push is refused that cycle and accepted the next;
//     no beat is lost or duplicated.
//  5. Drop path.
//     Stimulus: mask=0; send two 2-beat packets.
//     Required: tready=1 throughout, no output tvalid, drop_count=2.
//     Also preload drop_count near all-ones.
//     Required: it saturates.
//  6. Reset mid-packet.
//     Stimulus: assert sreset after beat 2 of 4 with data still buffered.
//     Required: all tvalid=0 next cycle, drop_count=0; the next beat (mask=2'b11, 0x55,
//     tlast=1) is delivered as a new single-beat packet on both outputs.

Source files
------------

// File: rtl/axis_broadcaster_pkg.sv
// axis_broadcaster_pkg: shared types and helpers for the buffered AXI-stream broadcaster
package axis_broadcaster_pkg;

    typedef enum logic {IDLE, IN_PKT} state_t;

    // One extra pointer bit distinguishes full from empty when the address bits match.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo: single-clock FIFO with registered occupancy and no fall-through
module axis_sync_fifo import axis_broadcaster_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             sreset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] data
);
    localparam int PW = ptr_width(DEPTH);

    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    assign valid = wr_ptr != rd_ptr;
    assign data  = mem[rd_ptr[PW-2:0]];

    // Pointer update; a full FIFO refuses the push even when it pops on the same edge.
    always_ff @(posedge clk) begin
        if (sreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ready && valid) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (!sreset && push && !full) mem[wr_ptr[PW-2:0]] <= push_data;
    end

endmodule

// File: rtl/axis_broadcaster_buffered.sv
// axis_broadcaster_buffered: replicates one AXI stream to per-output FIFOs under a per-packet mask
module axis_broadcaster_buffered import axis_broadcaster_pkg::*; #(
    parameter int AXIS_BYTES     = 1,
    parameter int AXIS_USER_BITS = 1,
    parameter int NUM_STREAMS    = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int DROP_CNT_BITS  = 16
) (
    input  logic                                   clk,
    input  logic                                   sreset,
    output logic                                   axis_i_tready,
    input  logic                                   axis_i_tvalid,
    input  logic                                   axis_i_tlast,
    input  logic [AXIS_BYTES*8-1:0]                axis_i_tdata,
    input  logic [AXIS_USER_BITS-1:0]              axis_i_tuser,
    input  logic [NUM_STREAMS-1:0]                 axis_i_mask,
    input  logic [NUM_STREAMS-1:0]                 axis_o_tready,
    output logic [NUM_STREAMS-1:0]                 axis_o_tvalid,
    output logic [NUM_STREAMS-1:0]                 axis_o_tlast,
    output logic [NUM_STREAMS*AXIS_BYTES*8-1:0]    axis_o_tdata,
    output logic [NUM_STREAMS*AXIS_USER_BITS-1:0]  axis_o_tuser,
    output logic [DROP_CNT_BITS-1:0]               drop_count
);
    localparam int DW = AXIS_BYTES * 8;
    localparam int UW = AXIS_USER_BITS;
    localparam int WW = DW + UW + 1;

    state_t                 state;
    logic [NUM_STREAMS-1:0] mask_q, act_mask, full;
    logic                   accept;

    assign act_mask      = (state == IDLE) ? axis_i_mask : mask_q;
    assign axis_i_tready = !sreset && !(|(act_mask & full));
    assign accept        = axis_i_tvalid && axis_i_tready;

    // Packet tracking: the mask is latched from the first beat and held until tlast.
    always_ff @(posedge clk) begin
        if (sreset) begin
            state      <= IDLE;
            mask_q     <= '0;
            drop_count <= '0;
        end else if (accept) begin
            state <= axis_i_tlast ? IDLE : IN_PKT;
            if (state == IDLE && !axis_i_tlast) mask_q <= axis_i_mask;
            if (state == IDLE && axis_i_mask == '0 && drop_count != '1)
                drop_count <= drop_count + DROP_CNT_BITS'(1);
        end
    end

    for (genvar i = 0; i < NUM_STREAMS; i++) begin : g_fifo
        logic [WW-1:0] q;
        axis_sync_fifo #(.WIDTH(WW), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk       (clk),
            .sreset    (sreset),
            .push      (accept && act_mask[i]),
            .push_data ({axis_i_tlast, axis_i_tuser, axis_i_tdata}),
            .full      (full[i]),
            .valid     (axis_o_tvalid[i]),
            .pop_ready (axis_o_tready[i]),
            .data      (q)
        );
        assign {axis_o_tlast[i], axis_o_tuser[i*UW +: UW], axis_o_tdata[i*DW +: DW]} = q;
    end

endmodule
